// File: rtl/rca_result_buf.sv
// Result FIFO behind a registered 32-bit adder stage with a fixed capture latency of 2.
// Defining RCA_RESULT_BUF_CO_COUNT_EN adds a saturating counter of carry-set results.
module rca_result_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   s_rca,
    input  logic          co_rca,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_sum,
    output logic          out_co,
    output logic [CW-1:0] count,
    output logic          err,
    output logic [7:0]    co_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] fill;
    logic [1:0]    pipe;
    logic          err_q;
    logic          full;
    logic          pop;
    logic          cap;
    logic          push;
    logic          drop;
    logic [CW:0]   occupancy;

    // Every in_valid is tracked, even without in_ready, so overruns are caught.
    assign cap       = pipe[1];
    assign full      = (fill == CW'(DEPTH));
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign push      = cap && (!full || pop);
    assign drop      = cap && full && !pop;

    assign occupancy = {1'b0, fill} + (CW+1)'(pipe[0]) + (CW+1)'(pipe[1]);
    assign in_ready  = (occupancy <= (CW+1)'(DEPTH - 1));

    assign out_sum  = mem[rd_ptr][31:0];
    assign out_co   = mem[rd_ptr][32];
    assign count    = fill;
    assign err      = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            pipe   <= '0;
            err_q  <= 1'b0;
        end else begin
            pipe <= {pipe[0], in_valid};
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fill <= fill + CW'(1);
            else if (pop && !push)
                fill <= fill - CW'(1);
            if (drop) err_q <= 1'b1;
        end
    end

    // Storage needs no reset; only the pointers and count define content.
    always_ff @(posedge clock) begin
        if (!reset && push)
            mem[wr_ptr] <= {co_rca, s_rca};
    end

`ifdef RCA_RESULT_BUF_CO_COUNT_EN
    logic [7:0] co_q;

    always_ff @(posedge clock) begin
        if (reset)
            co_q <= '0;
        else if (push && co_rca && co_q != 8'hFF)
            co_q <= co_q + 8'd1;
    end

    assign co_count = co_q;
`else
    assign co_count = 8'd0;
`endif

endmodule

// File: tb/tb_rca_result_buf.sv
// Bench for rca_result_buf: a two-register adder model feeds the DUT and a
// queue-based reference tracks stored results, overruns and the carry count.
module tb_rca_result_buf;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef RCA_RESULT_BUF_CO_COUNT_EN
    localparam bit CO_EN = 1'b1;
`else
    localparam bit CO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   s_rca = '0;
    logic          co_rca = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_sum;
    logic          out_co;
    logic [CW-1:0] count;
    logic          err;
    logic [7:0]    co_count;

    logic [31:0] a = '0, b = '0, a1 = '0, b1 = '0;
    logic        ci = 1'b0, ci1 = 1'b0;

    int checks = 0;
    int errors = 0;

    rca_result_buf #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .s_rca(s_rca), .co_rca(co_rca), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co),
        .count(count), .err(err), .co_count(co_count)
    );

    always #5 clock = ~clock;

    // Adder stage: operands registered at issue, sum registered one edge later.
    always @(posedge clock) begin
        a1 <= a;
        b1 <= b;
        ci1 <= ci;
        {co_rca, s_rca} <= {1'b0, a1} + {1'b0, b1} + 33'(ci1);
    end

    typedef struct {
        logic [32:0] v;
        int          due;
    } pend_t;

    logic [32:0] q[$];
    pend_t       pend[$];
    logic        m_err = 1'b0;
    int          m_co = 0;
    int          cyc = 0;

    // Reference: each accepted operand set lands two edges later, unless full.
    always @(posedge clock) begin
        logic  pop_m;
        logic  full_m;
        pend_t p;
        if (reset) begin
            q.delete();
            pend.delete();
            m_err = 1'b0;
            m_co = 0;
        end else begin
            pop_m = (q.size() != 0) && out_ready;
            full_m = (q.size() == DEPTH);
            if (pop_m) void'(q.pop_front());
            if (pend.size() != 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                if (!full_m || pop_m) begin
                    q.push_back(p.v);
                    if (CO_EN && p.v[32] && m_co < 255) m_co++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (in_valid) begin
                p.v = 33'(a) + 33'(b) + 33'(ci);
                p.due = cyc + 2;
                pend.push_back(p);
            end
        end
        cyc++;
    end

    logic [32:0] fq[$];

    task automatic fill_random();
        logic [32:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom;
            b = $urandom;
            ci = 1'($urandom % 2);
            v = 33'(a) + 33'(b) + 33'(ci);
            fq.push_back(v);
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state count=%0d ov=%b ir=%b want 0 0 1", count, out_valid, in_ready);
        end
        checks++;
        if (err !== 1'b0 || co_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags err=%b co=%0d want 0 0", err, co_count);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        a = 32'd5; b = 32'd7; ci = 1'b0;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early out_valid=%b want 0", out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd12 || out_co !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_result ov=%b sum=%0d co=%b cnt=%0d want 1 12 0 1",
                     out_valid, out_sum, out_co, count);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop count=%0d ov=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3};
        logic [31:0] tb[4] = '{32'd1, 32'd1, 32'd2, 32'd3};
        logic [31:0] es[4] = '{32'd0, 32'd2, 32'd4, 32'd6};
        logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        ci = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = ta[i];
            b = tb[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d in_ready=%b want 1", i, in_ready);
            end
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_ready in_ready=%b want 0", in_ready);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (count !== 3'd4 || co_count !== (CO_EN ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL b2b_full count=%0d co_count=%0d want 4 %0d", count, co_count, CO_EN);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== es[i] || out_co !== ec[i]) begin
                errors++;
                $display("FAIL b2b_pop_%0d ov=%b sum=%0d co=%b want 1 %0d %b",
                         i, out_valid, out_sum, out_co, es[i], ec[i]);
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drained count=%0d want 0", count);
        end
    endtask

    task automatic test_full_pop();
        logic [32:0] v;
        fq.delete();
        fill_random();
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_pre count=%0d ir=%b want 4 0", count, in_ready);
        end
        a = $urandom; b = $urandom; ci = 1'b1;
        fq.push_back(33'(a) + 33'(b) + 33'(ci));
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        void'(fq.pop_front());
        checks++;
        if (count !== 3'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_count count=%0d err=%b want 4 0", count, err);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = fq.pop_front();
            checks++;
            if ({out_co, out_sum} !== v || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fullpop_data_%0d got %h want %h", i, {out_co, out_sum}, v);
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        checks++;
        if (co_count !== 8'(m_co)) begin
            errors++;
            $display("FAIL fullpop_co co_count=%0d want %0d", co_count, m_co);
        end
    endtask

    task automatic test_overflow();
        logic [32:0] v;
        fq.delete();
        fill_random();
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (err !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_flag err=%b count=%0d want 1 4", err, count);
        end
        checks++;
        if (co_count !== 8'(m_co)) begin
            errors++;
            $display("FAIL overflow_co co_count=%0d want %0d", co_count, m_co);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = fq.pop_front();
            checks++;
            if ({out_co, out_sum} !== v) begin
                errors++;
                $display("FAIL overflow_data_%0d got %h want %h", i, {out_co, out_sum}, v);
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        checks++;
        if (err !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL overflow_sticky err=%b count=%0d want 1 0", err, count);
        end
    endtask

    task automatic test_mid_reset();
        a = $urandom; b = 32'hFFFF_FFFF; ci = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL midrst_%0d ov=%b count=%0d want 0 0", i, out_valid, count);
            end
            @(negedge clock);
        end
        checks++;
        if (err !== 1'b0 || co_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_flags err=%b co=%0d want 0 0", err, co_count);
        end
    endtask

    task automatic test_co_saturate();
        a = 32'hFFFF_FFFF; b = 32'd1; ci = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (262) @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        out_ready = 1'b0;
        checks++;
        if (co_count !== (CO_EN ? 8'd255 : 8'd0)) begin
            errors++;
            $display("FAIL co_saturate co_count=%0d want %0d", co_count, CO_EN ? 255 : 0);
        end
        checks++;
        if (count !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL co_sat_state count=%0d err=%b want 0 0", count, err);
        end
    endtask

    task automatic test_random();
        logic exp_ready;
        logic [32:0] head;
        for (int i = 0; i < 400; i++) begin
            exp_ready = (q.size() + pend.size()) <= DEPTH - 1;
            checks++;
            if (count !== CW'(q.size()) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_count cyc=%0d count=%0d ov=%b want %0d", i, count, out_valid, q.size());
            end
            checks++;
            if (in_ready !== exp_ready || err !== m_err || co_count !== 8'(m_co)) begin
                errors++;
                $display("FAIL rnd_flags cyc=%0d ir=%b err=%b co=%0d want %b %b %0d",
                         i, in_ready, err, co_count, exp_ready, m_err, m_co);
            end
            if (q.size() != 0) begin
                head = q[0];
                checks++;
                if ({out_co, out_sum} !== head) begin
                    errors++;
                    $display("FAIL rnd_head cyc=%0d got %h want %h", i, {out_co, out_sum}, head);
                end
            end
            a = $urandom;
            b = $urandom;
            ci = 1'($urandom % 2);
            in_valid = exp_ready ? 1'($urandom % 2) : ($urandom % 8 == 0);
            out_ready = 1'($urandom % 2);
            @(negedge clock);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_pop();
        test_overflow();
        test_mid_reset();
        test_co_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_result_buf.md
RCA_RESULT_BUF -- requirements
Module: rca_result_buf

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries; power of two, 2..16.
REQ-002 Parameter: CW, $clog2(DEPTH)+1, width of the count output.
REQ-003 Port: clock, input, 1, single rising-edge clock; the same clock drives the registered 32-bit adder stage.
REQ-004 Port: reset, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
REQ-005 Port: in_valid, input, 1, high in the cycle an operand set (a, b, ci) is presented to the adder stage.
REQ-006 Port: in_ready, output, 1, high when an operand set may be issued this cycle.
REQ-007 Port: s_rca, input, 32, registered sum from the adder stage.
REQ-008 Port: co_rca, input, 1, registered carry-out from the adder stage.
REQ-009 Port: out_valid, output, 1, head entry available.
REQ-010 Port: out_ready, input, 1, consumer accepts the head entry.
REQ-011 Port: out_sum, output, 32, head entry sum.
REQ-012 Port: out_co, output, 1, head entry carry.
REQ-013 Port: count, output, CW, number of stored entries.
REQ-014 Port: err, output, 1, sticky overflow flag.
REQ-015 Port: co_count, output, 8, number of results with carry set.

Function
REQ-016 An operand set is issued when in_valid && in_ready is high at rising edge N.
REQ-017 The result for that set is valid on s_rca/co_rca after edge N+1; the block shall capture it into the FIFO at edge N+2, which is a fixed latency of 2.
REQ-018 A 2-stage valid pipe shall track in-flight results; inflight is the number of set pipe bits (0..2).
REQ-019 in_ready shall equal (count + inflight + in_valid_issue_pending) < DEPTH. Simplified: in_ready = (count + inflight) <= DEPTH-1, and it is combinational.
REQ-020 A pop occurs when out_valid && out_ready at an edge; out_sum/out_co shall then present the next entry.
REQ-021 There shall be no bypass: a capture into an empty FIFO raises out_valid on the following cycle.
REQ-022 A simultaneous capture and pop shall leave count unchanged at any fill level, including full.
REQ-023 Read and write pointers shall wrap modulo DEPTH.
REQ-024 out_valid shall equal (count != 0); out_sum/out_co are don't-care while out_valid is low, and the bench shall not check them.
REQ-025 If in_valid is issued while in_ready is low and the capture finds the FIFO full with no simultaneous pop, the result shall be dropped and err set; err holds until reset.
REQ-026 out_sum/out_co shall hold stable while out_valid && !out_ready.

Reset
REQ-027 While reset is high at an edge: pointers=0, count=0, valid pipe=0, err=0, co_count=0; out_valid=0 and in_ready=1 from the next cycle.
REQ-028 Reset mid-operation shall discard in-flight and stored results; results emerging from the adder stage after reset shall be ignored.

Configuration
REQ-029 The macro RCA_RESULT_BUF_CO_COUNT_EN shall control the carry counter.
REQ-030 With RCA_RESULT_BUF_CO_COUNT_EN defined, co_count shall increment on each captured (not dropped) entry with carry=1 and saturate at 255.
REQ-031 Without RCA_RESULT_BUF_CO_COUNT_EN, co_count shall be tied to 0 and no counter logic shall exist.

Verification
REQ-032 Single issue: in_valid=1 for one cycle at edge N with a=5, b=7, ci=0 -> out_valid high after edge N+2; out_sum=12, out_co=0; count=1.
REQ-033 Back-to-back fill, DEPTH=4, out_ready=0: issue 0xFFFFFFFF+1, then 1+1, then 2+2, then 3+3 -> in_ready low after the 4th issue; count=4; pops return 0/co=1, 2, 4, 6 in order; co_count=1 with the macro defined.
REQ-034 Full FIFO, simultaneous capture and pop: count stays 4 and no entry is lost.
REQ-035 Forced overflow: in_valid issued with in_ready low at full and out_ready=0 -> err=1; count stays 4; stored data is unchanged.
REQ-036 Reset asserted one cycle after an issue -> no out_valid afterwards; count=0; err=0; co_count=0.
